// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window generator: FSM states and legal window sizes.
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned KSIZE_MIN = 3;
   localparam int unsigned KSIZE_MAX = 5;

   function automatic bit ksize_legal(input int unsigned k);
      return (k == KSIZE_MIN) || (k == KSIZE_MAX);
   endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-row delay RAM: reads the value stored one image row ago at addr, then overwrites it.
module sobel_line_buf
   import sobel_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);

   logic [PIX_W-1:0] mem [DEPTH];

   // Contents are deliberately not reset; stale rows are never used before being rewritten.
   always_ff @(posedge clk) begin
      if (en) mem[addr] <= din;
   end

   assign dout = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streams a raster image in and emits KSIZE x KSIZE sliding windows with their
// bottom-right coordinates, under valid/ready flow control on both sides.
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int PIX_W     = 8,
   parameter int KSIZE     = 3,
   parameter int MAX_WIDTH = 1024,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [CNT_W-1:0]             img_width,
   input  logic [CNT_W-1:0]             img_height,
   input  logic [PIX_W-1:0]             pixel_in,
   input  logic                         valid_in,
   output logic                         ready_in,
   output logic [KSIZE*KSIZE*PIX_W-1:0] win_out,
   output logic                         win_valid,
   input  logic                         ready_out,
   output logic [CNT_W-1:0]             win_col,
   output logic [CNT_W-1:0]             win_row,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         cfg_err
);

   localparam int unsigned      K     = KSIZE;
   localparam int               AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [CNT_W-1:0] K_C   = CNT_W'(KSIZE);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);
   localparam bit               K_OK  = ksize_legal(K);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] w_q, h_q, col_q, row_q;
   logic             accept, emit, last_pix, cfg_ok, start_ok, start_bad;
   logic [AW-1:0]    lb_addr;
   logic [PIX_W-1:0] lb_in   [K-1];
   logic [PIX_W-1:0] lb_out  [K-1];
   logic [PIX_W-1:0] col_vec [K];
   logic [PIX_W-1:0] win_q   [K][K];

   assign cfg_ok    = K_OK && (img_width >= K_C) && (img_width <= MAX_C) && (img_height >= K_C);
   assign start_ok  = (state_q == ST_IDLE) && start && cfg_ok;
   assign start_bad = (state_q == ST_IDLE) && start && !cfg_ok;
   assign accept    = valid_in && ready_in;
   assign emit      = (col_q >= K_C - 1'b1) && (row_q >= K_C - 1'b1);
   assign last_pix  = (col_q == w_q - 1'b1) && (row_q == h_q - 1'b1);
   assign lb_addr   = col_q[AW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      ready_in   = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_RUN;
         end
         ST_RUN: begin
            busy     = 1'b1;
            ready_in = !win_valid || ready_out;
            if (accept && last_pix) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (win_valid && ready_out) begin
               frame_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Line buffers are chained: buffer i delays the output of buffer i-1 by one more row.
   always_comb begin
      lb_in[0] = pixel_in;
      for (int unsigned i = 1; i < K - 1; i++) lb_in[i] = lb_out[i-1];
   end

   for (genvar i = 0; i < KSIZE - 1; i++) begin : g_lb
      sobel_line_buf #(
         .PIX_W (PIX_W),
         .DEPTH (MAX_WIDTH),
         .AW    (AW)
      ) u_lb (
         .clk  (clk),
         .en   (accept),
         .addr (lb_addr),
         .din  (lb_in[i]),
         .dout (lb_out[i])
      );
   end

   always_comb begin
      col_vec = '{default: '0};
      col_vec[K-1] = pixel_in;
      for (int unsigned r = 0; r < K - 1; r++) col_vec[r] = lb_out[K-2-r];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_q       <= '0;
         h_q       <= '0;
         col_q     <= '0;
         row_q     <= '0;
         win_valid <= 1'b0;
         win_col   <= '0;
         win_row   <= '0;
         cfg_err   <= 1'b0;
         win_q     <= '{default: '0};
      end else begin
         if (start_ok) begin
            w_q     <= img_width;
            h_q     <= img_height;
            col_q   <= '0;
            row_q   <= '0;
            cfg_err <= 1'b0;
         end else if (start_bad) begin
            cfg_err <= 1'b1;
         end

         // Windows only fire once col >= K-1, so the K shifted columns never span two rows.
         if (accept) begin
            for (int unsigned r = 0; r < K; r++) begin
               for (int unsigned c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
               win_q[r][K-1] <= col_vec[r];
            end
            if (col_q == w_q - 1'b1) begin
               col_q <= '0;
               row_q <= row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
            if (emit) begin
               win_col <= col_q;
               win_row <= row_q;
            end
            win_valid <= emit;
         end else if (ready_out) begin
            win_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      win_out = '0;
      for (int unsigned r = 0; r < K; r++)
         for (int unsigned c = 0; c < K; c++)
            win_out[(r*K+c)*PIX_W +: PIX_W] = win_q[r][c];
   end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed, table-driven bench for sobel_window_gen with K=3 and K=5 instances.
module tb_sobel_window_gen;

   localparam int PW = 8;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset = 1'b1, start = 1'b0;
   logic [CW-1:0]    img_width = '0, img_height = '0;
   logic [PW-1:0]    pixel_in = '0;
   logic             valid_in = 1'b0, ready_in;
   logic [9*PW-1:0]  win_out;
   logic             win_valid, ready_out = 1'b1;
   logic [CW-1:0]    win_col, win_row;
   logic             busy, frame_done, cfg_err;

   logic             reset5 = 1'b1, start5 = 1'b0;
   logic [CW-1:0]    img_width5 = '0, img_height5 = '0;
   logic [PW-1:0]    pixel_in5 = '0;
   logic             valid_in5 = 1'b0, ready_in5;
   logic [25*PW-1:0] win_out5;
   logic             win_valid5, ready_out5 = 1'b1;
   logic [CW-1:0]    win_col5, win_row5;
   logic             busy5, frame_done5, cfg_err5;

   sobel_window_gen #(.PIX_W(PW), .KSIZE(3), .MAX_WIDTH(1024), .CNT_W(CW)) dut3 (
      .clk(clk), .reset(reset), .start(start), .img_width(img_width), .img_height(img_height),
      .pixel_in(pixel_in), .valid_in(valid_in), .ready_in(ready_in), .win_out(win_out),
      .win_valid(win_valid), .ready_out(ready_out), .win_col(win_col), .win_row(win_row),
      .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err));

   sobel_window_gen #(.PIX_W(PW), .KSIZE(5), .MAX_WIDTH(1024), .CNT_W(CW)) dut5 (
      .clk(clk), .reset(reset5), .start(start5), .img_width(img_width5), .img_height(img_height5),
      .pixel_in(pixel_in5), .valid_in(valid_in5), .ready_in(ready_in5), .win_out(win_out5),
      .win_valid(win_valid5), .ready_out(ready_out5), .win_col(win_col5), .win_row(win_row5),
      .busy(busy5), .frame_done(frame_done5), .cfg_err(cfg_err5));

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [CW-1:0]   col;
      logic [CW-1:0]   row;
      logic [9*PW-1:0] win;
   } win_rec_t;

   typedef struct {
      logic [CW-1:0]    col;
      logic [CW-1:0]    row;
      logic [25*PW-1:0] win;
   } win5_rec_t;

   typedef struct {
      int   w;
      int   h;
      logic err;
   } cfg_vec_t;

   function automatic logic [9*PW-1:0] w9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
      return {PW'(a8), PW'(a7), PW'(a6), PW'(a5), PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
   endfunction

   // 5x5 window of a 6-wide raster whose top-left pixel value is tl.
   function automatic logic [25*PW-1:0] w25(input int tl);
      logic [25*PW-1:0] v;
      v = '0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            v[(i*5+j)*PW +: PW] = PW'(tl + 6*i + j);
      return v;
   endfunction

   win_rec_t  exp3[6];
   win_rec_t  got[$];
   win5_rec_t got5[$];
   int        fd_cnt = 0;
   int        fd5 = 0;
   logic      stalled = 1'b0;
   logic [2*CW+9*PW:0] held = '0;

   initial forever begin
      @(negedge clk);
      if (stalled && !reset)
         chk("stall_hold", 256'({win_valid, win_col, win_row, win_out}), 256'(held));
      if (win_valid && ready_out && !reset) got.push_back('{win_col, win_row, win_out});
      if (frame_done) fd_cnt++;
      stalled = win_valid && !ready_out;
      held    = {win_valid, win_col, win_row, win_out};
   end

   initial forever begin
      @(negedge clk);
      if (win_valid5 && ready_out5 && !reset5) got5.push_back('{win_col5, win_row5, win_out5});
      if (frame_done5) fd5++;
   end

   int rmode = 0;
   int rcyc  = 0;
   initial forever begin
      @(posedge clk);
      #1;
      rcyc++;
      ready_out = (rmode == 0) || (rcyc % 3 == 0);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset    = 1'b1;
      start    = 1'b0;
      valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      got.delete();
      fd_cnt = 0;
   endtask

   task automatic pulse_start(input int w, input int h);
      img_width  = CW'(w);
      img_height = CW'(h);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Sends pixels first+1 .. first+n; bogus_at injects a start pulse alongside that pixel.
   task automatic send_pixels(input int first, input int n, input int bogus_at);
      bit acc;
      int guard;
      for (int i = first; i < first + n; i++) begin
         pixel_in = PW'(i + 1);
         valid_in = 1'b1;
         if (i == bogus_at) begin
            img_width  = CW'(3);
            img_height = CW'(3);
            start      = 1'b1;
         end
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 50) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
            start = 1'b0;
            guard++;
         end
         if (!acc) begin
            chk("pixel_accept_timeout", 256'(0), 256'(1));
            valid_in = 1'b0;
            return;
         end
      end
      valid_in = 1'b0;
      pixel_in = 8'hEE;
   endtask

   task automatic wait_done(input string tag);
      int g;
      g = 0;
      while (fd_cnt == 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      repeat (3) @(negedge clk);
      chk({tag, "_frame_done_once"}, 256'(fd_cnt), 256'(1));
   endtask

   task automatic check_frame(input string tag);
      chk({tag, "_count"}, 256'(got.size()), 256'(6));
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         chk($sformatf("%s_w%0d_col", tag, i), 256'(got[i].col), 256'(exp3[i].col));
         chk($sformatf("%s_w%0d_row", tag, i), 256'(got[i].row), 256'(exp3[i].row));
         chk($sformatf("%s_w%0d_win", tag, i), 256'(got[i].win), 256'(exp3[i].win));
      end
      got.delete();
      fd_cnt = 0;
   endtask

   cfg_vec_t cv[6];

   initial begin
      exp3[0] = '{16'd2, 16'd2, w9(1, 2, 3, 6, 7, 8, 11, 12, 13)};
      exp3[1] = '{16'd3, 16'd2, w9(2, 3, 4, 7, 8, 9, 12, 13, 14)};
      exp3[2] = '{16'd4, 16'd2, w9(3, 4, 5, 8, 9, 10, 13, 14, 15)};
      exp3[3] = '{16'd2, 16'd3, w9(6, 7, 8, 11, 12, 13, 16, 17, 18)};
      exp3[4] = '{16'd3, 16'd3, w9(7, 8, 9, 12, 13, 14, 17, 18, 19)};
      exp3[5] = '{16'd4, 16'd3, w9(8, 9, 10, 13, 14, 15, 18, 19, 20)};
      cv[0] = '{2, 4, 1'b1};
      cv[1] = '{5, 2, 1'b1};
      cv[2] = '{1025, 4, 1'b1};
      cv[3] = '{1024, 3, 1'b0};
      cv[4] = '{3, 3, 1'b0};
      cv[5] = '{0, 0, 1'b1};

      // Reset values while reset is held.
      @(negedge clk);
      chk("rst_ready_in", 256'(ready_in), 256'(0));
      chk("rst_win_valid", 256'(win_valid), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_frame_done", 256'(frame_done), 256'(0));
      chk("rst_cfg_err", 256'(cfg_err), 256'(0));
      chk("rst_win_col_row", 256'({win_col, win_row}), 256'(0));
      chk("rst_win_out", 256'(win_out), 256'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic frame, with first-window latency checks.
      pulse_start(5, 4);
      chk("f1_busy_after_start", 256'(busy), 256'(1));
      send_pixels(0, 12, -1);
      chk("f1_no_window_yet", 256'(win_valid), 256'(0));
      send_pixels(12, 1, -1);
      chk("f1_first_win_valid", 256'(win_valid), 256'(1));
      chk("f1_first_win_pos", 256'({win_col, win_row}), 256'({16'd2, 16'd2}));
      send_pixels(13, 7, -1);
      wait_done("f1");
      check_frame("f1");
      chk("f1_idle_busy", 256'(busy), 256'(0));
      chk("f1_idle_ready_in", 256'(ready_in), 256'(0));

      // Downstream accepts only one cycle in three.
      rmode = 1;
      pulse_start(5, 4);
      send_pixels(0, 20, -1);
      wait_done("f2");
      check_frame("f2");
      rmode = 0;

      // Configuration legality table (fresh reset before each so cfg_err starts clear).
      for (int i = 0; i < 6; i++) begin
         do_reset();
         pulse_start(cv[i].w, cv[i].h);
         chk($sformatf("cfg%0d_err", i), 256'(cfg_err), 256'(cv[i].err));
         chk($sformatf("cfg%0d_busy", i), 256'(busy), 256'(!cv[i].err));
         chk($sformatf("cfg%0d_ready_in", i), 256'(ready_in), 256'(!cv[i].err));
      end

      // Bad start then good start without reset: error clears, frame runs normally.
      do_reset();
      pulse_start(2, 4);
      chk("err_seq_cfg_err", 256'(cfg_err), 256'(1));
      chk("err_seq_busy", 256'(busy), 256'(0));
      chk("err_seq_ready_in", 256'(ready_in), 256'(0));
      pulse_start(5, 4);
      chk("err_seq_cleared", 256'(cfg_err), 256'(0));
      send_pixels(0, 20, -1);
      wait_done("f3");
      check_frame("f3");

      // Reset mid-frame, then a clean frame.
      do_reset();
      pulse_start(5, 4);
      send_pixels(0, 12, -1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 256'(busy), 256'(0));
      chk("midrst_ready_in", 256'(ready_in), 256'(0));
      chk("midrst_win_valid", 256'(win_valid), 256'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      got.delete();
      fd_cnt = 0;
      pulse_start(5, 4);
      send_pixels(0, 20, -1);
      wait_done("f4");
      check_frame("f4");

      // Start pulse in the middle of RUN must be ignored.
      do_reset();
      pulse_start(5, 4);
      send_pixels(0, 20, 7);
      wait_done("f5");
      check_frame("f5");

      // K=5 instance: 6x5 frame yields two windows.
      @(posedge clk);
      #1;
      reset5      = 1'b0;
      img_width5  = CW'(6);
      img_height5 = CW'(5);
      start5      = 1'b1;
      @(posedge clk);
      #1;
      start5 = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bit acc;
         int guard;
         pixel_in5 = PW'(i + 1);
         valid_in5 = 1'b1;
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 50) begin
            @(negedge clk);
            acc = ready_in5;
            @(posedge clk);
            #1;
            guard++;
         end
         if (!acc) begin
            chk("k5_pixel_accept_timeout", 256'(0), 256'(1));
            break;
         end
      end
      valid_in5 = 1'b0;
      for (int g = 0; g < 100 && fd5 == 0; g++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("k5_frame_done_once", 256'(fd5), 256'(1));
      chk("k5_count", 256'(got5.size()), 256'(2));
      if (got5.size() >= 2) begin
         chk("k5_w0_pos", 256'({got5[0].col, got5[0].row}), 256'({16'd4, 16'd4}));
         chk("k5_w1_pos", 256'({got5[1].col, got5[1].row}), 256'({16'd5, 16'd4}));
         chk("k5_w0_top_row", 256'(got5[0].win[39:0]), 256'({8'd5, 8'd4, 8'd3, 8'd2, 8'd1}));
         chk("k5_w0_bottom_row", 256'(got5[0].win[199:160]), 256'({8'd29, 8'd28, 8'd27, 8'd26, 8'd25}));
         chk("k5_w0_win", 256'(got5[0].win), 256'(w25(1)));
         chk("k5_w1_win", 256'(got5[1].win), 256'(w25(2)));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
